// File: rtl/mem_port_arb_pkg.sv
// Shared types and helpers for the arbitrated single-port memory.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Number of byte lanes in a data word.
    function automatic int unsigned byte_lanes(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Requester-side bus of the arbitrated memory: per-channel request lanes
// packed side by side, one shared response.
interface mem_port_arb_if
    import mem_port_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = int'(byte_lanes(DATA_W));

    logic [NUM_CH-1:0]        req_i;
    logic [NUM_CH-1:0]        we_i;
    logic [NUM_CH*BE_W-1:0]   be_i;
    logic [NUM_CH*ADDR_W-1:0] addr_i;
    logic [NUM_CH*DATA_W-1:0] wdata_i;
    logic [NUM_CH-1:0]        ack_o;
    logic [DATA_W-1:0]        rdata_o;
    logic                     err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  ack_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output ack_o, rdata_o, err_o
    );

endinterface

// File: rtl/mem_port_arb_sp_ram.sv
// Single-port word RAM: byte-enable synchronous write, registered read.
module mem_port_arb_sp_ram
  import mem_port_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic                       we,
  input  logic [DATA_W/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);
  localparam int unsigned BE_W = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // One access per enabled cycle: masked byte write or full-word read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
          if (be[b]) begin
            mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Round-robin arbiter in front of a single-port RAM shared by NUM_CH
// requesters, with programmable wait states and an out-of-range flag.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter     INIT_FILE   = ""
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_port_arb_if.slave bus
);
    localparam int          BE_W  = int'(byte_lanes(DATA_W));
    localparam int          OFF_W = $clog2(BE_W);
    localparam int          IDX_W = $clog2(DEPTH);
    localparam int          PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned NCH   = NUM_CH;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    rr_ptr, winner, win_r, idx;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   addr_r, word_full;
    logic                we_r, err_r, oor, access;
    logic [BE_W-1:0]     be_r;
    logic [DATA_W-1:0]   wdata_r, ram_rdata;
    logic [NUM_CH-1:0]   ack_vec;

    logic [ADDR_W-1:0]   addr_ch  [NUM_CH];
    logic [DATA_W-1:0]   wdata_ch [NUM_CH];
    logic [BE_W-1:0]     be_ch    [NUM_CH];

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
            assign addr_ch[c]  = bus.addr_i[c*ADDR_W +: ADDR_W];
            assign wdata_ch[c] = bus.wdata_i[c*DATA_W +: DATA_W];
            assign be_ch[c]    = bus.be_i[c*BE_W +: BE_W];
        end
    endgenerate

    // Rotating priority: first requester at or after rr_ptr wins.
    always_comb begin
        logic found;
        winner = rr_ptr;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = PTR_W'((32'(rr_ptr) + i) % NCH);
            if (!found && bus.req_i[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state; the RAM access fires on the last wait-state edge.
    always_comb begin
        state_nxt = state;
        access    = 1'b0;
        case (state)
            ST_IDLE: if (|bus.req_i) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (cnt == '0) begin
                    access    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign word_full = addr_r >> OFF_W;
    assign oor       = word_full >= ADDR_W'(DEPTH);

    // Grant latch, wait counter, error flag and round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr  <= '0;
            cnt     <= '0;
            err_r   <= 1'b0;
            win_r   <= '0;
            addr_r  <= '0;
            we_r    <= 1'b0;
            be_r    <= '0;
            wdata_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.req_i) begin
                        win_r   <= winner;
                        addr_r  <= addr_ch[winner];
                        we_r    <= bus.we_i[winner];
                        be_r    <= be_ch[winner];
                        wdata_r <= wdata_ch[winner];
                        cnt     <= 4'(WAIT_STATES);
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) cnt   <= cnt - 4'd1;
                    else           err_r <= oor;
                end
                ST_RESP: begin
                    rr_ptr <= (win_r == PTR_W'(NCH - 1)) ? '0 : win_r + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    mem_port_arb_sp_ram #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk_i),
        .en    (access && !oor),
        .we    (we_r),
        .be    (be_r),
        .addr  (word_full[IDX_W-1:0]),
        .wdata (wdata_r),
        .rdata (ram_rdata)
    );

    // Response is decoded from RESP so an async reset drops it at once.
    always_comb begin
        ack_vec = '0;
        if (state == ST_RESP) ack_vec[win_r] = 1'b1;
    end

    assign bus.ack_o   = ack_vec;
    assign bus.err_o   = (state == ST_RESP) && err_r;
    assign bus.rdata_o = (state == ST_RESP && !we_r && !err_r) ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: one instance with no wait states, one with three.
module tb_mem_port_arb;

    typedef struct {
        int          ch;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          ch;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst0, rst3;
    always #5 clk = ~clk;

    logic [1:0]  req_v   [2];
    logic [1:0]  we_v    [2];
    logic [7:0]  be_v    [2];
    logic [63:0] addr_v  [2];
    logic [63:0] wdata_v [2];
    logic [1:0]  ack_v   [2];
    logic [31:0] rdata_v [2];
    logic        err_v   [2];

    mem_port_arb_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) bus0 ();
    mem_port_arb_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) bus3 ();

    assign bus0.req_i   = req_v[0];
    assign bus0.we_i    = we_v[0];
    assign bus0.be_i    = be_v[0];
    assign bus0.addr_i  = addr_v[0];
    assign bus0.wdata_i = wdata_v[0];
    assign ack_v[0]     = bus0.ack_o;
    assign rdata_v[0]   = bus0.rdata_o;
    assign err_v[0]     = bus0.err_o;

    assign bus3.req_i   = req_v[1];
    assign bus3.we_i    = we_v[1];
    assign bus3.be_i    = be_v[1];
    assign bus3.addr_i  = addr_v[1];
    assign bus3.wdata_i = wdata_v[1];
    assign ack_v[1]     = bus3.ack_o;
    assign rdata_v[1]   = bus3.rdata_o;
    assign err_v[1]     = bus3.err_o;

    mem_port_arb #(
        .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_STATES(0), .INIT_FILE("")
    ) dut0 (
        .clk_i(clk), .rst_i(rst0), .bus(bus0)
    );

    mem_port_arb #(
        .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_STATES(3), .INIT_FILE("")
    ) dut3 (
        .clk_i(clk), .rst_i(rst3), .bus(bus3)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t q0[$];
    exp_t q3[$];
    exp_t e0, e3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expected response of that instance.
    always @(negedge clk) begin
        if (ack_v[0] != 2'b00) begin
            if (q0.size() == 0) begin
                check("dut0_spurious_ack", 32'(ack_v[0]), 32'h0);
            end else begin
                e0 = q0.pop_front();
                check("dut0_ack_ch", 32'(ack_v[0]), 32'(2'b01 << e0.ch));
                check("dut0_rdata", rdata_v[0], e0.rd);
                check("dut0_err", 32'(err_v[0]), 32'(e0.err));
            end
        end
        if (ack_v[1] != 2'b00) begin
            if (q3.size() == 0) begin
                check("dut3_spurious_ack", 32'(ack_v[1]), 32'h0);
            end else begin
                e3 = q3.pop_front();
                check("dut3_ack_ch", 32'(ack_v[1]), 32'(2'b01 << e3.ch));
                check("dut3_rdata", rdata_v[1], e3.rd);
                check("dut3_err", 32'(err_v[1]), 32'(e3.err));
            end
        end
    end

    // Single access starting at a negedge; checks ack latency in cycles.
    task automatic do_acc(input int sel, input vec_t v, input int exp_lat, input string name);
        exp_t e;
        int   k;
        e.ch  = v.ch;
        e.rd  = v.exp_rd;
        e.err = v.exp_err;
        if (sel == 0) q0.push_back(e);
        else          q3.push_back(e);
        req_v[sel]                   = 2'b00;
        we_v[sel][v.ch]              = v.we;
        be_v[sel][v.ch*4 +: 4]       = v.be;
        addr_v[sel][v.ch*32 +: 32]   = v.addr;
        wdata_v[sel][v.ch*32 +: 32]  = v.wdata;
        req_v[sel][v.ch]             = 1'b1;
        k = 0;
        while (k < 30 && ack_v[sel] == 2'b00) begin
            @(negedge clk);
            k++;
        end
        check({name, "_latency"}, 32'(k), 32'(exp_lat));
        req_v[sel] = 2'b00;
        @(negedge clk);
    endtask

    vec_t vecs[16];
    vec_t w;
    int   n;

    initial begin
        vecs[0]  = '{1, 1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1, 1'b0, 4'h0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{0, 1'b1, 4'hF, 32'h20,       32'h11223344, 32'h0,        1'b0};
        vecs[3]  = '{0, 1'b1, 4'h5, 32'h20,       32'hAABBCCDD, 32'h0,        1'b0};
        vecs[4]  = '{1, 1'b0, 4'h0, 32'h20,       32'h0,        32'h11BB33DD, 1'b0};
        vecs[5]  = '{0, 1'b0, 4'hF, 32'h13,       32'h0,        32'hDEADBEEF, 1'b0};
        vecs[6]  = '{0, 1'b1, 4'hF, 32'h0,        32'h12345678, 32'h0,        1'b0};
        vecs[7]  = '{1, 1'b1, 4'hF, 32'h100,      32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[8]  = '{0, 1'b0, 4'h0, 32'h100,      32'h0,        32'h0,        1'b1};
        vecs[9]  = '{1, 1'b0, 4'h0, 32'h0,        32'h0,        32'h12345678, 1'b0};
        vecs[10] = '{0, 1'b1, 4'hF, 32'hFC,       32'hCAFEF00D, 32'h0,        1'b0};
        vecs[11] = '{1, 1'b1, 4'h8, 32'hFE,       32'h99000000, 32'h0,        1'b0};
        vecs[12] = '{0, 1'b0, 4'h0, 32'hFC,       32'h0,        32'h99FEF00D, 1'b0};
        vecs[13] = '{1, 1'b0, 4'h0, 32'hFFFFFFF0, 32'h0,        32'h0,        1'b1};
        vecs[14] = '{1, 1'b1, 4'hF, 32'h30,       32'h5555AAAA, 32'h0,        1'b0};
        vecs[15] = '{0, 1'b0, 4'h0, 32'h30,       32'h0,        32'h5555AAAA, 1'b0};

        for (int s = 0; s < 2; s++) begin
            req_v[s] = '0; we_v[s] = '0; be_v[s] = '0; addr_v[s] = '0; wdata_v[s] = '0;
        end
        rst0 = 1'b1;
        rst3 = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_ack0", 32'(ack_v[0]), 32'h0);
        check("reset_rdata0", rdata_v[0], 32'h0);
        check("reset_err0", 32'(err_v[0]), 32'h0);
        check("reset_ack3", 32'(ack_v[1]), 32'h0);
        rst0 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            do_acc(0, vecs[i], 2, $sformatf("vec%0d", i));
        end

        // Reset while a write to 0x30 is in WAIT: write must be dropped.
        we_v[0]            = 2'b10;
        be_v[0][7:4]       = 4'hF;
        addr_v[0][63:32]   = 32'h30;
        wdata_v[0][63:32]  = 32'h0BADF00D;
        req_v[0]           = 2'b10;
        @(posedge clk);
        #2 rst0 = 1'b1;
        #1 check("rst_wait_ack", 32'(ack_v[0]), 32'h0);
        @(negedge clk);
        req_v[0] = 2'b00;
        @(negedge clk);
        rst0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_wait_no_ack", 32'(ack_v[0]), 32'h0);
        end

        // Contention right after reset: ch0 first, then strict alternation.
        we_v[0]           = 2'b00;
        addr_v[0][31:0]   = 32'h0;
        addr_v[0][63:32]  = 32'h30;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) q0.push_back('{0, 32'h12345678, 1'b0});
            else            q0.push_back('{1, 32'h5555AAAA, 1'b0});
        end
        req_v[0] = 2'b11;
        n = 0;
        for (int k = 0; k < 60 && n < 8; k++) begin
            @(negedge clk);
            if (ack_v[0] != 2'b00) begin
                n++;
                if (n == 8) req_v[0] = 2'b00;
            end
        end
        check("contention_acks", 32'(n), 32'd8);
        repeat (3) @(negedge clk);

        // Three wait states: ack five cycles after the request is sampled.
        w = '{0, 1'b1, 4'hF, 32'h8, 32'h0F0F0F0F, 32'h0, 1'b0};
        do_acc(1, w, 5, "ws3_write");
        w = '{1, 1'b0, 4'h0, 32'h8, 32'h0, 32'h0F0F0F0F, 1'b0};
        do_acc(1, w, 5, "ws3_read");
        w = '{0, 1'b0, 4'h0, 32'h100, 32'h0, 32'h0, 1'b1};
        do_acc(1, w, 5, "ws3_oor");

        // Reset during RESP clears the ack without waiting for a clock.
        we_v[1]          = 2'b00;
        addr_v[1][31:0]  = 32'h8;
        req_v[1]         = 2'b01;
        repeat (5) @(posedge clk);
        #1 check("resp_ack_before_rst", 32'(ack_v[1]), 32'h1);
        check("resp_rdata_before_rst", rdata_v[1], 32'h0F0F0F0F);
        rst3 = 1'b1;
        #1 check("resp_ack_after_rst", 32'(ack_v[1]), 32'h0);
        check("resp_rdata_after_rst", rdata_v[1], 32'h0);
        @(negedge clk);
        req_v[1] = 2'b00;
        @(negedge clk);
        rst3 = 1'b0;
        repeat (3) @(negedge clk);

        check("dut0_queue_empty", 32'(q0.size()), 32'h0);
        check("dut3_queue_empty", 32'(q3.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
